program_loader_rom: RTL and testbench

//  Instruction-side responder for the cpu fetch interface: holds up to 256 32-bit

---
 rtl/program_loader_rom.sv | 211 +++++++++++++++++++++
 tb/tb_program_loader_rom.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_rom.sv
// ============================================================================
// program_loader_rom
// ----------------------------------------------------------------------------
// Instruction-side responder for the cpu fetch interface. It holds up to DEPTH
// 32-bit instruction words and returns mem[instruction_pointer] to the core
// with zero latency. Programs arrive as a valid/ready byte stream and are
// packed MSB-first (big-endian) into words. The block also owns cpu run
// control. It holds the core in reset while a program is loading. Once the
// program is running, it generates the cpu clock-enable strobe. The strobe
// fires on every cycle in turbo mode, or once every TURBO_DIV cycles otherwise.
//
// Ports
//   clk_i                  in   1   system clock
//   reset_i                in   1   synchronous, active-high reset
//   load_start_i           in   1   pulse: begin a new program load at word 0
//   load_valid_i           in   1   load_byte_i is valid
//   load_ready_o           out  1   a byte is accepted this cycle if valid
//   load_byte_i            in   8   program byte, MSB-first within each word
//   load_last_i            in   1   marks the final byte of the program
//   instruction_pointer_i  in   8   fetch address from the cpu
//   instruction_o          out  32  instruction word to the cpu
//   turbo_i                in   1   1: cpu_enable every cycle, 0: divided
//   cpu_enable_o           out  1   clock-enable strobe to the cpu
//   cpu_resetn_o           out  1   active-low cpu reset, low unless running
//   busy_o                 out  1   high while a program is loading
//   word_count_o           out  9   words in the current program (0..256)
//   load_error_o           out  1   sticky: short final word or overflow
// ============================================================================
module program_loader_rom #(
    parameter int DEPTH     = 256,
    parameter int TURBO_DIV = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_start_i,
    input  logic        load_valid_i,
    output logic        load_ready_o,
    input  logic [7:0]  load_byte_i,
    input  logic        load_last_i,
    input  logic [7:0]  instruction_pointer_i,
    output logic [31:0] instruction_o,
    input  logic        turbo_i,
    output logic        cpu_enable_o,
    output logic        cpu_resetn_o,
    output logic        busy_o,
    output logic [8:0]  word_count_o,
    output logic        load_error_o
);

    localparam int                CW       = $clog2(TURBO_DIV);
    localparam logic [CW-1:0]     DIV_LAST = CW'(TURBO_DIV - 1);
    localparam logic [7:0]        LAST_ADR = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t          state_q,      state_d;
    logic [1:0]      byte_idx_q,   byte_idx_d;
    logic [7:0]      wr_addr_q,    wr_addr_d;
    logic [8:0]      word_count_q, word_count_d;
    logic            load_error_q, load_error_d;
    logic [23:0]     word_buf_q,   word_buf_d;
    logic [CW-1:0]   div_cnt_q,    div_cnt_d;
    logic            load_ready_q, load_ready_d;
    logic            busy_q,       busy_d;
    logic            run_q,        run_d;

    logic            accept;
    logic            word_done;
    logic            mem_we;
    logic [31:0]     assembled;

    logic [31:0]     mem_q [0:DEPTH-1];

    // The first three bytes of a word wait in word_buf. The word is built
    // from the buffered bytes, the incoming byte, and zeros in the lanes not
    // yet received. The zeros matter when load_last arrives early: the
    // buffer may still hold stale bytes from the previous word in those lanes.
    always_comb begin
        assembled = {word_buf_q, load_byte_i};
        case (byte_idx_q)
            2'd0:    assembled = {load_byte_i, 24'h000000};
            2'd1:    assembled = {word_buf_q[23:16], load_byte_i, 16'h0000};
            2'd2:    assembled = {word_buf_q[23:8], load_byte_i, 8'h00};
            default: assembled = {word_buf_q, load_byte_i};
        endcase
    end

    // Next-state logic for the loader and the run controller. load_start wins
    // over a byte presented in the same cycle. In that case the byte is
    // dropped and nothing is written. A word is committed to memory either
    // when its fourth byte arrives or when load_last ends it early. The
    // outputs are computed from the next state so that they come straight
    // out of flops. This leaves no combinational path from the load inputs
    // to the cpu controls.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        load_error_d = load_error_q;
        word_buf_d   = word_buf_q;
        mem_we       = 1'b0;

        accept    = (state_q == S_LOAD) && load_valid_i;
        word_done = accept && ((byte_idx_q == 2'd3) || load_last_i);

        if (load_start_i) begin
            state_d      = S_LOAD;
            byte_idx_d   = 2'd0;
            wr_addr_d    = 8'd0;
            word_count_d = 9'd0;
            load_error_d = 1'b0;
        end else if (accept) begin
            if (!word_done) begin
                case (byte_idx_q)
                    2'd0:    word_buf_d[23:16] = load_byte_i;
                    2'd1:    word_buf_d[15:8]  = load_byte_i;
                    default: word_buf_d[7:0]   = load_byte_i;
                endcase
                byte_idx_d = byte_idx_q + 2'd1;
            end else begin
                mem_we       = 1'b1;
                byte_idx_d   = 2'd0;
                word_count_d = word_count_q + 9'd1;
                if (load_last_i) begin
                    state_d = S_RUN;
                    if (byte_idx_q != 2'd3) begin
                        load_error_d = 1'b1;
                    end
                end else if (wr_addr_q == LAST_ADR) begin
                    state_d      = S_RUN;
                    load_error_d = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + 8'd1;
                end
            end
        end

        // The divider restarts from zero whenever RUN is entered. Within RUN
        // it counts on every cycle, even while turbo is on. Because of this,
        // the slow strobes stay on the same grid after turbo is dropped.
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + CW'(1);
        end else begin
            div_cnt_d = '0;
        end

        load_ready_d = (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD);
        run_d        = (state_d == S_RUN);
    end

    // State register with synchronous reset. A reset in the middle of a load
    // throws away the partial word. It also clears word_count, so every read
    // returns zero until a new program has been loaded.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            wr_addr_q    <= 8'd0;
            word_count_q <= 9'd0;
            load_error_q <= 1'b0;
            word_buf_q   <= 24'h000000;
            div_cnt_q    <= '0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            load_error_q <= load_error_d;
            word_buf_q   <= word_buf_d;
            div_cnt_q    <= div_cnt_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            run_q        <= run_d;
        end
    end

    // Instruction storage. It has no reset, so words survive a reset. They
    // are simply hidden behind word_count. Writes are blocked during reset
    // so that a word completing in that cycle is discarded.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem_q[wr_addr_q] <= assembled;
        end
    end

    // Zero-latency fetch. Addresses past the end of the loaded program, or
    // any address while the core is not running, read back as zero.
    always_comb begin
        instruction_o = 32'h0000_0000;
        if (run_q && ({1'b0, instruction_pointer_i} < word_count_q)) begin
            instruction_o = mem_q[instruction_pointer_i];
        end
    end

    assign load_ready_o = load_ready_q;
    assign busy_o       = busy_q;
    assign cpu_resetn_o = run_q;
    assign cpu_enable_o = run_q && (turbo_i || (div_cnt_q == DIV_LAST));
    assign word_count_o = word_count_q;
    assign load_error_o = load_error_q;

endmodule

// File: tb/tb_program_loader_rom.sv
// ============================================================================
// tb_program_loader_rom
// ----------------------------------------------------------------------------
// Directed sequence of program loads with randomized byte pacing and contents.
// Expected words, counts and error flags come from a byte-list model of the
// program image. The expected cpu_enable pattern is derived from the RUN
// cycle number.
// ============================================================================
module tb_program_loader_rom;

    localparam int TURBO_DIV = 4;

    logic        clk_i;
    logic        reset_i;
    logic        load_start_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [7:0]  load_byte_i;
    logic        load_last_i;
    logic [7:0]  instruction_pointer_i;
    logic [31:0] instruction_o;
    logic        turbo_i;
    logic        cpu_enable_o;
    logic        cpu_resetn_o;
    logic        busy_o;
    logic [8:0]  word_count_o;
    logic        load_error_o;

    int          vectors;
    int          miscompares;
    int          accepted;

    logic [7:0]  progBytes[$];
    logic [31:0] expMem[256];
    int          expWc;
    logic        expErr;

    program_loader_rom #(
        .DEPTH    (256),
        .TURBO_DIV(TURBO_DIV)
    ) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .load_start_i         (load_start_i),
        .load_valid_i         (load_valid_i),
        .load_ready_o         (load_ready_o),
        .load_byte_i          (load_byte_i),
        .load_last_i          (load_last_i),
        .instruction_pointer_i(instruction_pointer_i),
        .instruction_o        (instruction_o),
        .turbo_i              (turbo_i),
        .cpu_enable_o         (cpu_enable_o),
        .cpu_resetn_o         (cpu_resetn_o),
        .busy_o               (busy_o),
        .word_count_o         (word_count_o),
        .load_error_o         (load_error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of loader inputs, then clock it in.
    task automatic applyStimulus(input logic start, input logic valid,
                                 input logic [7:0] b, input logic last);
        load_start_i = start;
        load_valid_i = valid;
        load_byte_i  = b;
        load_last_i  = last;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Stream progBytes into the loader with random valid gaps. Stops early if
    // the loader stops being ready.
    task automatic sendBytes(input bit withLast);
        int  i;
        int  guard;
        bit  drive;
        i        = 0;
        guard    = 0;
        accepted = 0;
        while (i < progBytes.size() && guard < 8000) begin
            guard++;
            if (load_ready_o !== 1'b1) break;
            drive = ($urandom_range(0, 3) != 0);
            if (drive) begin
                applyStimulus(1'b0, 1'b1, progBytes[i],
                              withLast && (i == progBytes.size() - 1));
                i++;
                accepted++;
            end else begin
                applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            end
        end
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    // Reference image: bytes taken four at a time, big-endian, with the last
    // word zero-padded and the image capped at 256 words.
    task automatic buildModel(input int n, input bit lastSeen);
        logic [31:0] w;
        expWc = (n + 3) / 4;
        if (expWc > 256) expWc = 256;
        for (int wi = 0; wi < expWc; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4 * wi + k < n) begin
                    w = w | (32'(progBytes[4 * wi + k]) << (24 - 8 * k));
                end
            end
            expMem[wi] = w;
        end
        expErr = lastSeen ? ((n % 4) != 0) : (expWc == 256);
    endtask

    task automatic checkReads(input string tag);
        for (int p = 0; p < 256; p++) begin
            instruction_pointer_i = 8'(p);
            @(negedge clk_i);
            checkOutput($sformatf("%s_read[%0d]", tag, p), instruction_o,
                        (p < expWc) ? expMem[p] : 32'h0);
        end
        tick();
    endtask

    task automatic checkRun(input string tag);
        checkOutput({tag, "_resetn"},     {31'b0, cpu_resetn_o}, 32'd1);
        checkOutput({tag, "_busy"},       {31'b0, busy_o},       32'd0);
        checkOutput({tag, "_ready"},      {31'b0, load_ready_o}, 32'd0);
        checkOutput({tag, "_word_count"}, {23'b0, word_count_o}, 32'(expWc));
        checkOutput({tag, "_load_error"}, {31'b0, load_error_o}, {31'b0, expErr});
        checkReads(tag);
    endtask

    task automatic checkLoading(input string tag);
        checkOutput({tag, "_busy"},   {31'b0, busy_o},       32'd1);
        checkOutput({tag, "_ready"},  {31'b0, load_ready_o}, 32'd1);
        checkOutput({tag, "_resetn"}, {31'b0, cpu_resetn_o}, 32'd0);
        checkOutput({tag, "_enable"}, {31'b0, cpu_enable_o}, 32'd0);
        checkOutput({tag, "_wc"},     {23'b0, word_count_o}, 32'd0);
        checkOutput({tag, "_err"},    {31'b0, load_error_o}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  expEn;
        logic [7:0] b;

        vectors               = 0;
        miscompares           = 0;
        reset_i               = 1'b1;
        load_start_i          = 1'b0;
        load_valid_i          = 1'b0;
        load_byte_i           = 8'h00;
        load_last_i           = 1'b0;
        instruction_pointer_i = 8'h00;
        turbo_i               = 1'b0;

        // Reset and idle.
        repeat (3) tick();
        reset_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            turbo_i               = c[0];
            instruction_pointer_i = 8'($urandom_range(0, 255));
            #1;
            checkOutput("idle_resetn", {31'b0, cpu_resetn_o}, 32'd0);
            checkOutput("idle_enable", {31'b0, cpu_enable_o}, 32'd0);
            checkOutput("idle_ready",  {31'b0, load_ready_o}, 32'd0);
            checkOutput("idle_busy",   {31'b0, busy_o},       32'd0);
            checkOutput("idle_instr",  instruction_o,         32'h0);
            tick();
        end
        turbo_i = 1'b0;
        checkOutput("idle_wc",  {23'b0, word_count_o}, 32'd0);
        checkOutput("idle_err", {31'b0, load_error_o}, 32'd0);

        // Two full words.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkLoading("loadA");
        progBytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        sendBytes(1'b1);
        checkOutput("loadA_accepted", 32'(accepted), 32'd8);
        buildModel(8, 1'b1);
        checkRun("loadA");

        // Short final word, then the divided / turbo enable pattern, measured
        // from the first RUN cycle.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        progBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        sendBytes(1'b1);
        for (int rc = 1; rc <= 24; rc++) begin
            turbo_i = (rc >= 13 && rc <= 16);
            #1;
            expEn = turbo_i || ((rc % TURBO_DIV) == 0);
            checkOutput($sformatf("enable_cycle%0d", rc), {31'b0, cpu_enable_o}, {31'b0, expEn});
            tick();
        end
        turbo_i = 1'b0;
        checkOutput("loadB_accepted", 32'(accepted), 32'd5);
        buildModel(5, 1'b1);
        checkRun("loadB");

        // Random-length program.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        n = $urandom_range(1, 40);
        progBytes.delete();
        for (int i = 0; i < n; i++) progBytes.push_back(8'($urandom_range(0, 255)));
        sendBytes(1'b1);
        checkOutput("rand_accepted", 32'(accepted), 32'(n));
        buildModel(n, 1'b1);
        checkRun("rand");

        // Overflow: more bytes than fit, no load_last.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        progBytes.delete();
        for (int i = 0; i < 1028; i++) progBytes.push_back(8'($urandom_range(0, 255)));
        sendBytes(1'b0);
        checkOutput("ovf_accepted", 32'(accepted), 32'd1024);
        buildModel(1024, 1'b0);
        checkRun("ovf");

        // Restart mid-word: the byte presented with load_start is dropped.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        progBytes = '{8'h11, 8'h22};
        sendBytes(1'b0);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
        load_valid_i = 1'b0;
        checkLoading("restart");
        progBytes = '{8'h44, 8'h55, 8'h66, 8'h77};
        sendBytes(1'b1);
        buildModel(4, 1'b1);
        checkRun("restart");

        // Reset after six bytes of a new load.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        progBytes.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(1, 255));
            progBytes.push_back(b);
        end
        sendBytes(1'b0);
        checkOutput("midrst_accepted", 32'(accepted), 32'd6);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        turbo_i = 1'b1;
        expWc   = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("midrst_wc",     {23'b0, word_count_o}, 32'd0);
            checkOutput("midrst_resetn", {31'b0, cpu_resetn_o}, 32'd0);
            checkOutput("midrst_enable", {31'b0, cpu_enable_o}, 32'd0);
            checkOutput("midrst_busy",   {31'b0, busy_o},       32'd0);
            checkOutput("midrst_err",    {31'b0, load_error_o}, 32'd0);
            tick();
        end
        for (int p = 0; p < 4; p++) begin
            instruction_pointer_i = 8'(p);
            @(negedge clk_i);
            checkOutput($sformatf("midrst_read[%0d]", p), instruction_o, 32'h0);
        end
        turbo_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
